// File: rtl/blake2_round_seq.sv
// BLAKE2 round engine: runs the full SIGMA-scheduled G-call sequence over a
// 16-word working vector, NG column/diagonal calls per clock.
//
//   state | meaning
//   IDLE  | waiting for a block, ready_o high
//   RUN   | NG G calls per cycle, round/step counters advancing
//   DONE  | result held on v_o with valid_o high until ready_i
module blake2_round_seq #(
  parameter int W  = 64,
  parameter int R  = 12,
  parameter int NG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [16*W-1:0] v_i,
  input  logic [16*W-1:0] m_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [16*W-1:0] v_o,
  output logic            busy_o
);

  localparam int ROT_A = (W == 64) ? 32 : 16;
  localparam int ROT_B = (W == 64) ? 24 : 12;
  localparam int ROT_C = (W == 64) ? 16 : 8;
  localparam int ROT_D = (W == 64) ? 63 : 7;

  localparam logic [2:0] STEP_INC   = 3'(NG);
  localparam logic [2:0] LAST_STEP  = 3'(8 - NG);
  localparam logic [3:0] LAST_ROUND = 4'(R - 1);

  if (W != 64 && W != 32) begin : g_bad_w
    $error("blake2_round_seq: W must be 32 or 64");
  end
  if (NG != 1 && NG != 2 && NG != 4) begin : g_bad_ng
    $error("blake2_round_seq: NG must be 1, 2 or 4");
  end
  if (R < 1 || R > 12) begin : g_bad_r
    $error("blake2_round_seq: R must be in 1..12");
  end

  typedef logic [W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  word_t      v_reg [16];
  word_t      m_reg [16];
  word_t      v_nxt [16];
  logic [3:0] round;
  logic [2:0] step;
  logic [3:0] sig_row;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [4*W-1:0] g_mix(input word_t a, input word_t b,
                                           input word_t c, input word_t d,
                                           input word_t x, input word_t y);
    a = a + b + x;
    d = rotr(d ^ a, ROT_A);
    c = c + d;
    b = rotr(b ^ c, ROT_B);
    a = a + b + y;
    d = rotr(d ^ a, ROT_C);
    c = c + d;
    b = rotr(b ^ c, ROT_D);
    return {a, b, c, d};
  endfunction

  // Vector indices {a,b,c,d} touched by G call g (columns 0-3, diagonals 4-7).
  function automatic logic [15:0] g_lanes(input logic [2:0] g);
    logic [15:0] l;
    case (g)
      3'd0:    l = {4'd0, 4'd4, 4'd8,  4'd12};
      3'd1:    l = {4'd1, 4'd5, 4'd9,  4'd13};
      3'd2:    l = {4'd2, 4'd6, 4'd10, 4'd14};
      3'd3:    l = {4'd3, 4'd7, 4'd11, 4'd15};
      3'd4:    l = {4'd0, 4'd5, 4'd10, 4'd15};
      3'd5:    l = {4'd1, 4'd6, 4'd11, 4'd12};
      3'd6:    l = {4'd2, 4'd7, 4'd8,  4'd13};
      default: l = {4'd3, 4'd4, 4'd9,  4'd14};
    endcase
    return l;
  endfunction

  // SIGMA rows packed with entry e in nibble e (entry 15 is the leftmost digit).
  function automatic logic [3:0] sigma(input logic [3:0] row, input logic [3:0] e);
    logic [63:0] r;
    case (row)
      4'd1:    r = 64'h357B20C16DF984AE;
      4'd2:    r = 64'h491763EADF250C8B;
      4'd3:    r = 64'h8F04A562EBCD1397;
      4'd4:    r = 64'hD386CB1EFA427509;
      4'd5:    r = 64'h91EF57D438B0A6C2;
      4'd6:    r = 64'hB8293670A4DEF15C;
      4'd7:    r = 64'hA2684F05931CE7BD;
      4'd8:    r = 64'h5A417D2C803B9EF6;
      4'd9:    r = 64'h0DC3E9BF5167482A;
      default: r = 64'hFEDCBA9876543210;
    endcase
    return r[{e, 2'b00} +: 4];
  endfunction

  always_comb begin
    sig_row = (round >= 4'd10) ? round - 4'd10 : round;
  end

  // Calls within one cycle hit disjoint lanes, so applying them in sequence
  // on a shared copy is equivalent to running them in parallel.
  always_comb begin
    logic [2:0]     g;
    logic [15:0]    lanes;
    logic [3:0]     ia, ib, ic, id;
    logic [4*W-1:0] mixed;
    g     = '0;
    lanes = '0;
    ia    = '0;
    ib    = '0;
    ic    = '0;
    id    = '0;
    mixed = '0;
    for (int k = 0; k < 16; k++) v_nxt[k] = v_reg[k];
    for (int j = 0; j < NG; j++) begin
      g     = step + 3'(j);
      lanes = g_lanes(g);
      ia    = lanes[15:12];
      ib    = lanes[11:8];
      ic    = lanes[7:4];
      id    = lanes[3:0];
      mixed = g_mix(v_nxt[ia], v_nxt[ib], v_nxt[ic], v_nxt[id],
                    m_reg[sigma(sig_row, {g, 1'b0})],
                    m_reg[sigma(sig_row, {g, 1'b1})]);
      v_nxt[ia] = mixed[4*W-1:3*W];
      v_nxt[ib] = mixed[3*W-1:2*W];
      v_nxt[ic] = mixed[2*W-1:W];
      v_nxt[id] = mixed[W-1:0];
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_vout
    assign v_o[k*W +: W] = v_reg[k];
  end

  // Gated by rst so the engine reads not-ready while held in reset, yet is
  // ready on the very first cycle after release.
  assign ready_o = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      round   <= '0;
      step    <= '0;
      for (int k = 0; k < 16; k++) begin
        v_reg[k] <= '0;
        m_reg[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            for (int k = 0; k < 16; k++) begin
              v_reg[k] <= v_i[k*W +: W];
              m_reg[k] <= m_i[k*W +: W];
            end
            round  <= '0;
            step   <= '0;
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < 16; k++) v_reg[k] <= v_nxt[k];
          if (step == LAST_STEP) begin
            step <= '0;
            if (round == LAST_ROUND) begin
              busy_o  <= 1'b0;
              valid_o <= 1'b1;
              state   <= DONE;
            end else begin
              round <= round + 4'd1;
            end
          end else begin
            step <= step + STEP_INC;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blake2_round_seq.sv
// Bench for blake2_round_seq: six engine configurations checked against the
// known "abc" digests and a software BLAKE2 round model on random blocks.
module tb_blake2_round_seq;

  localparam int NRAND = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [5:0]    valid_in, ready_in, ready_out, valid_out, busy_out;
  logic [1023:0] v_in, m_in;
  logic [1023:0] v_out [6];

  // Config gi: W=64/R=12 for gi<3, W=32/R=10 otherwise; NG = 1,2,4 cycling.
  for (genvar gi = 0; gi < 6; gi++) begin : g_dut
    localparam int WI = (gi < 3) ? 64 : 32;
    localparam int RI = (gi < 3) ? 12 : 10;
    localparam int NI = 1 << (gi % 3);
    logic [16*WI-1:0] vo;
    blake2_round_seq #(.W(WI), .R(RI), .NG(NI)) u_dut (
      .clk(clk), .rst(rst),
      .valid_i(valid_in[gi]), .ready_o(ready_out[gi]),
      .v_i(v_in[16*WI-1:0]), .m_i(m_in[16*WI-1:0]),
      .valid_o(valid_out[gi]), .ready_i(ready_in[gi]),
      .v_o(vo), .busy_o(busy_out[gi])
    );
    assign v_out[gi] = 1024'(vo);
  end

  int checks = 0;
  int errors = 0;

  logic [63:0]   mv [16];
  logic [63:0]   mm [16];
  logic [63:0]   ev [16];
  logic [63:0]   hinit [8];
  logic [1023:0] last_v;

  logic [63:0] iv64 [8] = '{64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B,
                            64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
                            64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F,
                            64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179};

  int sig [10][16] = '{
    '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
    '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
    '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
    '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
    '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
    '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
    '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
    '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
    '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}};

  typedef struct {
    int           cfg;
    logic [63:0]  m0;
    int           lat;
    logic [511:0] digest;
  } abc_vec_t;
  abc_vec_t tbl [4];

  function automatic int cfg_w(input int ci);  return (ci < 3) ? 64 : 32; endfunction
  function automatic int cfg_r(input int ci);  return (ci < 3) ? 12 : 10; endfunction
  function automatic int cfg_ng(input int ci); return 1 << (ci % 3);      endfunction

  function automatic logic [63:0] mask_of(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    return ((x >> n) | (x << (w - n))) & mask_of(w);
  endfunction

  function automatic logic [63:0] word_of(input logic [1023:0] vec, input int w, input int k);
    return (w == 64) ? vec[k*64 +: 64] : {32'h0, vec[k*32 +: 32]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 64'(act), 64'(exp));
  endtask

  task automatic chk_vec(input string nm, input logic [1023:0] act, input int w);
    int bad;
    bad = -1;
    checks++;
    for (int k = 15; k >= 0; k--)
      if (word_of(act, w, k) !== ev[k]) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: word %0d got %h expected %h", nm, bad, word_of(act, w, bad), ev[bad]);
    end
  endtask

  // Reference: R rounds of four column then four diagonal G calls on mv/mm.
  task automatic model_run(input int w, input int r);
    logic [63:0] mk, a, b, c, d, x, y;
    int ra, rb, rc, rd;
    int ln [4];
    mk = mask_of(w);
    ra = (w == 64) ? 32 : 16;
    rb = (w == 64) ? 24 : 12;
    rc = (w == 64) ? 16 : 8;
    rd = (w == 64) ? 63 : 7;
    for (int k = 0; k < 16; k++) ev[k] = mv[k];
    for (int rr = 0; rr < r; rr++) begin
      for (int gi = 0; gi < 8; gi++) begin
        int q;
        q = gi % 4;
        if (gi < 4) ln = '{q, q + 4, q + 8, q + 12};
        else        ln = '{q, 4 + (q + 1) % 4, 8 + (q + 2) % 4, 12 + (q + 3) % 4};
        x = mm[sig[rr % 10][2*gi]];
        y = mm[sig[rr % 10][2*gi + 1]];
        a = ev[ln[0]]; b = ev[ln[1]]; c = ev[ln[2]]; d = ev[ln[3]];
        a = (a + b + x) & mk; d = rotr(d ^ a, ra, w);
        c = (c + d) & mk;     b = rotr(b ^ c, rb, w);
        a = (a + b + y) & mk; d = rotr(d ^ a, rc, w);
        c = (c + d) & mk;     b = rotr(b ^ c, rd, w);
        ev[ln[0]] = a; ev[ln[1]] = b; ev[ln[2]] = c; ev[ln[3]] = d;
      end
    end
  endtask

  // Single final block of 3 bytes, unkeyed, full-length digest.
  task automatic setup_abc(input int w, input logic [63:0] m0);
    logic [63:0] mk;
    mk = mask_of(w);
    for (int k = 0; k < 8; k++)
      hinit[k] = (w == 64) ? iv64[k] : {32'h0, iv64[k][63:32]};
    hinit[0] ^= (w == 64) ? 64'h0000_0000_0101_0040 : 64'h0000_0000_0101_0020;
    for (int k = 0; k < 8; k++) begin
      mv[k]     = hinit[k];
      mv[k + 8] = (w == 64) ? iv64[k] : {32'h0, iv64[k][63:32]};
    end
    mv[12] ^= 64'd3;              // byte counter t0 = 3
    mv[14]  = ~mv[14] & mk;       // final-block flag
    for (int k = 0; k < 16; k++) mm[k] = '0;
    mm[0] = m0;
  endtask

  task automatic setup_random(input int w);
    for (int k = 0; k < 16; k++) begin
      mv[k] = {$urandom, $urandom} & mask_of(w);
      mm[k] = {$urandom, $urandom} & mask_of(w);
    end
  endtask

  task automatic drive_block(input int w);
    v_in = '0;
    m_in = '0;
    for (int k = 0; k < 16; k++) begin
      if (w == 64) begin
        v_in[k*64 +: 64] = mv[k];
        m_in[k*64 +: 64] = mm[k];
      end else begin
        v_in[k*32 +: 32] = mv[k][31:0];
        m_in[k*32 +: 32] = mm[k][31:0];
      end
    end
  endtask

  task automatic run_block(input int ci, input int exp_lat, input int stall);
    int w, c;
    logic [1023:0] snap;
    w = cfg_w(ci);
    model_run(w, cfg_r(ci));
    c = 0;
    while (!ready_out[ci] && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk1($sformatf("cfg%0d ready_o before accept", ci), ready_out[ci], 1'b1);
    drive_block(w);
    valid_in[ci] = 1'b1;
    @(negedge clk);
    valid_in[ci] = 1'b0;
    v_in = {32{$urandom}};
    m_in = {32{$urandom}};
    chk1($sformatf("cfg%0d ready_o in RUN", ci), ready_out[ci], 1'b0);
    chk1($sformatf("cfg%0d busy_o in RUN", ci), busy_out[ci], 1'b1);
    c = 1;
    while (!valid_out[ci] && c < exp_lat + 20) begin
      @(negedge clk);
      c++;
    end
    chk($sformatf("cfg%0d valid_o latency", ci), 64'(c), 64'(exp_lat));
    chk1($sformatf("cfg%0d busy_o in DONE", ci), busy_out[ci], 1'b0);
    snap = v_out[ci];
    for (int s = 0; s < stall; s++) begin
      valid_in[ci] = 1'($urandom_range(0, 1));
      v_in = {32{$urandom}};
      m_in = {32{$urandom}};
      @(negedge clk);
      chk1($sformatf("cfg%0d ready_o in DONE", ci), ready_out[ci], 1'b0);
    end
    valid_in[ci] = 1'b0;
    if (stall > 0) begin
      chk1($sformatf("cfg%0d valid_o held", ci), valid_out[ci], 1'b1);
      chk1($sformatf("cfg%0d v_o stable in DONE", ci), v_out[ci] == snap, 1'b1);
    end
    ready_in[ci] = 1'b1;
    @(negedge clk);
    ready_in[ci] = 1'b0;
    chk1($sformatf("cfg%0d valid_o after take", ci), valid_out[ci], 1'b0);
    chk1($sformatf("cfg%0d ready_o after take", ci), ready_out[ci], 1'b1);
    chk_vec($sformatf("cfg%0d result", ci), snap, w);
    last_v = snap;
  endtask

  task automatic abc_case(input int t, input int stall);
    int ci, w;
    logic [63:0] h;
    ci = tbl[t].cfg;
    w  = cfg_w(ci);
    setup_abc(w, tbl[t].m0);
    run_block(ci, tbl[t].lat, stall);
    for (int k = 0; k < 8; k++) begin
      h = hinit[k] ^ word_of(last_v, w, k) ^ word_of(last_v, w, k + 8);
      chk($sformatf("cfg%0d abc digest word %0d", ci, k), h, tbl[t].digest[k*64 +: 64]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] dig_b, dig_s;
    dig_b = {64'h239900D4ED8623B9, 64'h5A92F1DBA88AD318, 64'h95CC3345DED552C2,
             64'h2D79AB2A39C5877D, 64'hD1A2FFDB6FBB124B, 64'hB7C45A68142F214C,
             64'hE9F6129FB697276A, 64'h0D4D1C983FA580BA};
    dig_s = {64'h82596786, 64'h4C9B994D, 64'h293AD69E, 64'h208B4537,
             64'h2F45EB4E, 64'hA32BA7E1, 64'hE2147C32, 64'h8C5E8C50};
    tbl[0] = '{0, 64'h636261, 97, dig_b};
    tbl[1] = '{1, 64'h636261, 49, dig_b};
    tbl[2] = '{2, 64'h636261, 25, dig_b};
    tbl[3] = '{5, 64'h636261, 21, dig_s};

    rst = 1'b1;
    valid_in = '0;
    ready_in = '0;
    v_in = '0;
    m_in = '0;
    #12;
    chk("reset ready_o", 64'(ready_out), 64'h0);
    chk("reset valid_o", 64'(valid_out), 64'h0);
    chk("reset busy_o", 64'(busy_out), 64'h0);
    chk1("reset v_o zero", |v_out[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_o after reset", 64'(ready_out), 64'h3F);
    @(negedge clk);

    for (int t = 0; t < 4; t++) abc_case(t, 2);

    // Back-pressure: 10 stalled DONE cycles with valid_i pulsing new data.
    setup_random(64);
    run_block(2, 25, 10);

    // Asynchronous reset in the middle of RUN.
    setup_abc(64, 64'h636261);
    chk1("cfg0 ready_o before abort", ready_out[0], 1'b1);
    drive_block(64);
    valid_in[0] = 1'b1;
    @(negedge clk);
    valid_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk1("cfg0 busy_o before abort", busy_out[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("abort v_o zero", |v_out[0], 1'b0);
    chk1("abort busy_o", busy_out[0], 1'b0);
    chk1("abort valid_o", valid_out[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("abort ready_o after release", ready_out[0], 1'b1);
    @(negedge clk);
    abc_case(0, 1);

    for (int ci = 0; ci < 6; ci++) begin
      for (int n = 0; n < NRAND; n++) begin
        setup_random(cfg_w(ci));
        run_block(ci, 8 * cfg_r(ci) / cfg_ng(ci) + 1, int'($urandom_range(0, 3)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
